// File: rtl/serial_subtractor_pipe_if.sv
// rtl/serial_subtractor_pipe_if.sv - operand/result handshake bundle for the digit-serial subtractor
// Optional macro: ABS_DIFF_EN adds the abs_diff result field.
interface serial_subtractor_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;
`ifdef ABS_DIFF_EN
  logic [WIDTH-1:0] abs_diff;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, neg, ovf, abs_diff
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, neg, ovf, abs_diff
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, neg, ovf
  );
`endif
endinterface

// File: rtl/serial_subtractor_pipe.sv
// rtl/serial_subtractor_pipe.sv - digit-serial a - b - bin subtractor with zero/neg/ovf flags
// Optional macro: ABS_DIFF_EN adds an ABS state and the abs_diff magnitude output.
module serial_subtractor_pipe #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_subtractor_pipe_if.slave bus
);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_subtractor_pipe: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
  end

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

`ifdef ABS_DIFF_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABS, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  // work_q accumulates digits; the visible diff_q is only loaded on entry to DONE
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
`ifdef ABS_DIFF_EN
  logic [WIDTH-1:0] abs_q, abs_d;
`endif

  int               digit_lsb;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   sub_dig;
  logic             load_out;
  logic [WIDTH-1:0] fin_diff;
  logic             fin_borrow;

  assign digit_lsb = int'(cnt_q) * DIGIT;

  // One digit of the subtraction; the top bit of the DIGIT+1 result is the borrow out
  always_comb begin
    a_dig   = a_q[digit_lsb +: DIGIT];
    b_dig   = b_q[digit_lsb +: DIGIT];
    sub_dig = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_q};
  end

  // Next-state and datapath updates; result registers load only when the final value is ready
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    borrow_d   = borrow_q;
    work_d     = work_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
`ifdef ABS_DIFF_EN
    abs_d      = abs_q;
`endif
    load_out   = 1'b0;
    fin_diff   = work_q;
    fin_borrow = borrow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          work_d   = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        work_d[digit_lsb +: DIGIT] = sub_dig[DIGIT-1:0];
        borrow_d                   = sub_dig[DIGIT];
        cnt_d                      = cnt_q + CW'(1);
        if (cnt_q == LAST_DIG) begin
          cnt_d = '0;
`ifdef ABS_DIFF_EN
          state_d = S_ABS;
`else
          fin_diff   = work_d;
          fin_borrow = sub_dig[DIGIT];
          load_out   = 1'b1;
          state_d    = S_DONE;
`endif
        end
      end
`ifdef ABS_DIFF_EN
      S_ABS: begin
        load_out = 1'b1;
        state_d  = S_DONE;
      end
`endif
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_out) begin
      diff_d = fin_diff;
      bout_d = fin_borrow;
      zero_d = (fin_diff == '0);
      neg_d  = fin_diff[WIDTH-1];
      ovf_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (fin_diff[WIDTH-1] ^ a_q[WIDTH-1]);
`ifdef ABS_DIFF_EN
      abs_d  = fin_borrow ? (~fin_diff + WIDTH'(1)) : fin_diff;
`endif
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      work_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ABS_DIFF_EN
      abs_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
`ifdef ABS_DIFF_EN
      abs_q    <= abs_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
`ifdef ABS_DIFF_EN
  assign bus.abs_diff  = abs_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_pipe.sv
// tb/tb_serial_subtractor_pipe.sv - directed and sweep checks for serial_subtractor_pipe
module tb_serial_subtractor_pipe;

`ifdef ABS_DIFF_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT16 = 4 + EXTRA;
  localparam int PER16 = LAT16 + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_subtractor_pipe_if #(.WIDTH(16)) bus16 ();
  serial_subtractor_pipe_if #(.WIDTH(32)) bus_d1 ();
  serial_subtractor_pipe_if #(.WIDTH(32)) bus_d8 ();
  serial_subtractor_pipe_if #(.WIDTH(32)) bus_d32 ();

  serial_subtractor_pipe #(.WIDTH(16), .DIGIT(4))  u_dut16  (.clk(clk), .rst_n(rst_n), .bus(bus16));
  serial_subtractor_pipe #(.WIDTH(32), .DIGIT(1))  u_dut_d1 (.clk(clk), .rst_n(rst_n), .bus(bus_d1));
  serial_subtractor_pipe #(.WIDTH(32), .DIGIT(8))  u_dut_d8 (.clk(clk), .rst_n(rst_n), .bus(bus_d8));
  serial_subtractor_pipe #(.WIDTH(32), .DIGIT(32)) u_dut_d32(.clk(clk), .rst_n(rst_n), .bus(bus_d32));

  // shared stimulus for the three 32-bit instances
  logic        s_in_valid = 1'b0;
  logic        s_out_ready = 1'b0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic        s_bin = 1'b0;

  assign bus_d1.in_valid  = s_in_valid;  assign bus_d1.a  = s_a; assign bus_d1.b  = s_b;
  assign bus_d1.bin       = s_bin;       assign bus_d1.out_ready  = s_out_ready;
  assign bus_d8.in_valid  = s_in_valid;  assign bus_d8.a  = s_a; assign bus_d8.b  = s_b;
  assign bus_d8.bin       = s_bin;       assign bus_d8.out_ready  = s_out_ready;
  assign bus_d32.in_valid = s_in_valid;  assign bus_d32.a = s_a; assign bus_d32.b = s_b;
  assign bus_d32.bin      = s_bin;       assign bus_d32.out_ready = s_out_ready;

  logic        w_ov  [3];
  logic        w_rdy [3];
  logic [31:0] w_diff[3];
  logic        w_bout[3];
  logic        w_ovf [3];
  assign w_ov[0] = bus_d1.out_valid;  assign w_ov[1] = bus_d8.out_valid;  assign w_ov[2] = bus_d32.out_valid;
  assign w_rdy[0] = bus_d1.in_ready;  assign w_rdy[1] = bus_d8.in_ready;  assign w_rdy[2] = bus_d32.in_ready;
  assign w_diff[0] = bus_d1.diff;     assign w_diff[1] = bus_d8.diff;     assign w_diff[2] = bus_d32.diff;
  assign w_bout[0] = bus_d1.bout;     assign w_bout[1] = bus_d8.bout;     assign w_bout[2] = bus_d32.bout;
  assign w_ovf[0] = bus_d1.ovf;       assign w_ovf[1] = bus_d8.ovf;       assign w_ovf[2] = bus_d32.ovf;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one operand set into the 16-bit instance and measure cycles to out_valid
  task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb_op, input logic tbin,
                          output int lat);
    int guard;
    guard = 0;
    while (bus16.in_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    bus16.a        = ta;
    bus16.b        = tb_op;
    bus16.bin      = tbin;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 50) begin
      step();
      lat++;
    end
    if (bus16.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic release16();
    bus16.out_ready = 1'b1;
    step();
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    checks++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", bus16.in_ready, bus16.out_valid);
    end
    checks++;
    if ({bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: diff=%h bout=%b zero=%b neg=%b ovf=%b, required all 0",
               bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf);
    end
`ifdef ABS_DIFF_EN
    checks++;
    if (bus16.abs_diff !== 16'h0) begin
      errors++;
      $display("FAIL reset_abs_diff: got %h, required 0000", bus16.abs_diff);
    end
`endif
    // abort a calculation part-way through RUN
    bus16.a = 16'h1234; bus16.b = 16'h0234; bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run_ready: in_ready=%b, required 1", bus16.in_ready);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus16.out_valid !== 1'b0 || bus16.diff !== 16'h0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_run_no_result: %0d cycles showed a result, required 0", bad);
    end
  endtask

  task automatic test_basic();
    int lat;
    run_op16(16'h1234, 16'h0234, 1'b0, lat);
    checks++;
    if (lat != LAT16) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, required %0d", lat, LAT16);
    end
    checks++;
    if ({bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf} !== {16'h1000, 4'b0000}) begin
      errors++;
      $display("FAIL basic_result: diff=%h flags(bout,zero,neg,ovf)=%b%b%b%b, required 1000 0000",
               bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf);
    end
    release16();
  endtask

  task automatic test_borrow_in();
    int lat;
    run_op16(16'h0005, 16'h0005, 1'b1, lat);
    checks++;
    if (lat != LAT16) begin
      errors++;
      $display("FAIL borrow_in_latency: got %0d cycles, required %0d", lat, LAT16);
    end
    checks++;
    if ({bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf} !== {16'hFFFF, 4'b1010}) begin
      errors++;
      $display("FAIL borrow_in_result: diff=%h flags(bout,zero,neg,ovf)=%b%b%b%b, required ffff 1010",
               bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf);
    end
`ifdef ABS_DIFF_EN
    checks++;
    if (bus16.abs_diff !== 16'h0001) begin
      errors++;
      $display("FAIL borrow_in_abs: got %h, required 0001", bus16.abs_diff);
    end
`endif
    release16();
  endtask

  task automatic test_overflow_zero();
    int lat;
    run_op16(16'h8000, 16'h0001, 1'b0, lat);
    checks++;
    if ({bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf} !== {16'h7FFF, 4'b0001}) begin
      errors++;
      $display("FAIL overflow_result: diff=%h flags(bout,zero,neg,ovf)=%b%b%b%b, required 7fff 0001",
               bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf);
    end
`ifdef ABS_DIFF_EN
    checks++;
    if (bus16.abs_diff !== 16'h7FFF) begin
      errors++;
      $display("FAIL overflow_abs: got %h, required 7fff", bus16.abs_diff);
    end
`endif
    release16();
    run_op16(16'h0003, 16'h0003, 1'b0, lat);
    checks++;
    if ({bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf} !== {16'h0000, 4'b0100}) begin
      errors++;
      $display("FAIL zero_result: diff=%h flags(bout,zero,neg,ovf)=%b%b%b%b, required 0000 0100",
               bus16.diff, bus16.bout, bus16.zero, bus16.neg, bus16.ovf);
    end
    release16();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_op16(16'h0010, 16'h0020, 1'b0, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 || bus16.diff !== 16'hFFF0 ||
          bus16.bout !== 1'b1) bad++;
      bus16.a = 16'h7777; bus16.b = 16'h1111;
      bus16.in_valid = i[0];
      step();
    end
    bus16.in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d of 10 cycles lost the held result, required 0", bad);
    end
    release16();
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0/1",
               bus16.out_valid, bus16.in_ready);
    end
    bad = 0;
    for (int i = 0; i < LAT16 + 3; i++) begin
      if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_ignored_inputs: %0d cycles left IDLE, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int first_acc;
    int second_acc;
    int results;
    int bad;
    first_acc = -1; second_acc = -1; results = 0; bad = 0;
    bus16.a = 16'h00FF; bus16.b = 16'h0001; bus16.bin = 1'b0;
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    for (int c = 0; c < 3 * PER16 + 2; c++) begin
      if (bus16.in_ready === 1'b1) begin
        if (first_acc < 0) first_acc = c;
        else if (second_acc < 0) second_acc = c;
      end
      if (bus16.out_valid === 1'b1) begin
        results++;
        if (bus16.diff !== 16'h00FE) bad++;
      end
      step();
    end
    bus16.in_valid = 1'b0;
    checks++;
    if (second_acc - first_acc != PER16) begin
      errors++;
      $display("FAIL back_to_back_period: got %0d cycles between accepts, required %0d",
               second_acc - first_acc, PER16);
    end
    checks++;
    if (results < 2 || bad != 0) begin
      errors++;
      $display("FAIL back_to_back_results: %0d results, %0d wrong, required >=2 and 0 wrong", results, bad);
    end
    repeat (PER16 + 2) step();
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    int          lat_exp[3];
    logic [32:0] ref_full;
    logic        ref_ovf;
    logic        done[3];
    int          cyc;
    int          guard;
    lat_exp[0] = 32 + EXTRA; lat_exp[1] = 4 + EXTRA; lat_exp[2] = 1 + EXTRA;
    s_out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      guard = 0;
      while (!(w_rdy[0] === 1'b1 && w_rdy[1] === 1'b1 && w_rdy[2] === 1'b1) && guard < 60) begin
        step();
        guard++;
      end
      s_a   = $urandom;
      s_b   = $urandom;
      s_bin = 1'($urandom_range(0, 1));
      if (n == 0) begin s_a = 32'h0000_0005; s_b = 32'h0000_0005; s_bin = 1'b1; end
      if (n == 1) begin s_a = 32'h8000_0000; s_b = 32'h0000_0001; s_bin = 1'b0; end
      ref_full = {1'b0, s_a} - {1'b0, s_b} - {32'h0, s_bin};
      ref_ovf  = (s_a[31] != s_b[31]) && (ref_full[31] != s_a[31]);
      s_in_valid = 1'b1;
      step();
      s_in_valid = 1'b0;
      done[0] = 1'b0; done[1] = 1'b0; done[2] = 1'b0;
      cyc = 0;
      while (!(done[0] && done[1] && done[2]) && cyc < 60) begin
        for (int k = 0; k < 3; k++) begin
          if (!done[k] && w_ov[k] === 1'b1) begin
            done[k] = 1'b1;
            checks++;
            if ({w_bout[k], w_diff[k], w_ovf[k]} !== {ref_full[32], ref_full[31:0], ref_ovf}) begin
              errors++;
              $display("FAIL sweep_result[%0d] op %0d: a=%h b=%h bin=%b got diff=%h bout=%b ovf=%b, required diff=%h bout=%b ovf=%b",
                       k, n, s_a, s_b, s_bin, w_diff[k], w_bout[k], w_ovf[k], ref_full[31:0], ref_full[32], ref_ovf);
            end
            checks++;
            if (cyc != lat_exp[k]) begin
              errors++;
              $display("FAIL sweep_latency[%0d] op %0d: got %0d, required %0d", k, n, cyc, lat_exp[k]);
            end
          end
        end
        step();
        cyc++;
      end
      for (int k = 0; k < 3; k++) begin
        if (!done[k]) begin
          checks++;
          errors++;
          $display("FAIL sweep_timeout[%0d] op %0d: no out_valid within 60 cycles, required one", k, n);
        end
      end
    end
    s_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_in();
    test_overflow_zero();
    test_backpressure();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
